// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the dynamic branch predictor.
//   - bpCounter_t : 2-bit saturating direction counter encodings
//   - pcSrc_t     : PC-source select encodings used by the fetch mux consumer
//   - COUNTER_RESET / COUNTER_ALLOC : counter value after reset / on allocate
//   - counterNext : saturating increment (taken) or decrement (not taken)
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } bpCounter_t;

  typedef enum logic [1:0] {
    PCSRC_PCPLUS4F    = 2'b00,
    PCSRC_PREDTARGETF = 2'b01,
    PCSRC_PCPLUS4E    = 2'b10,
    PCSRC_PCTARGETE   = 2'b11
  } pcSrc_t;

  localparam bpCounter_t COUNTER_RESET = WEAK_NT;
  localparam bpCounter_t COUNTER_ALLOC = WEAK_T;

  function automatic bpCounter_t counterNext(input bpCounter_t cur, input logic taken);
    bpCounter_t nxt;
    nxt = cur;
    if (taken) begin
      if (cur != STRONG_T) nxt = bpCounter_t'(cur + 2'b01);
    end else begin
      if (cur != STRONG_NT) nxt = bpCounter_t'(cur - 2'b01);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_target_table.sv
// Direct-mapped branch target table.
//   F read port  : pcF -> predTakenF, predTargetF (combinational, zero latency)
//   E RMW port   : update, pcE, takenE, targetE -> trains counter/target or
//                  allocates on a taken miss, applied at the clock edge
// A same-cycle read and write of one index returns the old contents to F.
module branch_target_table
  import branch_predictor_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ENTRIES = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pcF,
  output logic             predTakenF,
  output logic [WIDTH-1:0] predTargetF,
  input  logic             update,
  input  logic [WIDTH-1:0] pcE,
  input  logic             takenE,
  input  logic [WIDTH-1:0] targetE
);

  localparam int INDEX_W = $clog2(ENTRIES);
  localparam int TAG_W   = WIDTH - INDEX_W - 2;

  logic             validArr   [ENTRIES];
  logic [TAG_W-1:0] tagArr     [ENTRIES];
  logic [WIDTH-1:0] targetArr  [ENTRIES];
  bpCounter_t       counterArr [ENTRIES];

  logic [INDEX_W-1:0] indexF, indexE;
  logic [TAG_W-1:0]   tagF, tagE;
  logic               hitF, hitE;
  logic               unusedLowBits;

  // Instructions are word aligned, so PC[1:0] carries no information.
  assign unusedLowBits = ^{pcF[1:0], pcE[1:0]};

  assign indexF = pcF[INDEX_W+1:2];
  assign tagF   = pcF[WIDTH-1:INDEX_W+2];
  assign indexE = pcE[INDEX_W+1:2];
  assign tagE   = pcE[WIDTH-1:INDEX_W+2];

  assign hitF        = validArr[indexF] && (tagArr[indexF] == tagF);
  assign predTakenF  = hitF && counterArr[indexF][1];
  assign predTargetF = hitF ? targetArr[indexF] : '0;

  assign hitE = validArr[indexE] && (tagArr[indexE] == tagE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        validArr[i]   <= 1'b0;
        tagArr[i]     <= '0;
        targetArr[i]  <= '0;
        counterArr[i] <= COUNTER_RESET;
      end
    end else if (update) begin
      if (hitE) begin
        counterArr[indexE] <= counterNext(counterArr[indexE], takenE);
        if (takenE) targetArr[indexE] <= targetE;
      end else if (takenE) begin
        // Taken miss: claim the slot, evicting whatever aliased into it.
        validArr[indexE]   <= 1'b1;
        tagArr[indexE]     <= tagE;
        targetArr[indexE]  <= targetE;
        counterArr[indexE] <= COUNTER_ALLOC;
      end
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor top level.
//   Inputs : clk, reset_n, PCF, StallD/FlushD, StallE/FlushE, BranchE, PCE,
//            PCSrcResE, PCTargetE
//   Outputs: PCSrcPredF/PredPCTargetF (F lookup), PCSrcPredE (prediction carried
//            to E), TargetMatchE, MispredictCount (saturating perf counter)
// Holds the F->D and D->E prediction registers (flush beats stall) and trains
// the table when a branch or jump resolves in an unstalled E stage.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ENTRIES = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] PCF,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic             BranchE,
  input  logic [WIDTH-1:0] PCE,
  input  logic             PCSrcResE,
  input  logic [WIDTH-1:0] PCTargetE,
  output logic             PCSrcPredF,
  output logic [WIDTH-1:0] PredPCTargetF,
  output logic             PCSrcPredE,
  output logic             TargetMatchE,
  output logic [31:0]      MispredictCount
);

  logic             predD, predE;
  logic [WIDTH-1:0] targetD, targetE;
  logic             updE, mispredictE;

  branch_target_table #(
    .WIDTH   (WIDTH),
    .ENTRIES (ENTRIES)
  ) btt (
    .clk         (clk),
    .reset_n     (reset_n),
    .pcF         (PCF),
    .predTakenF  (PCSrcPredF),
    .predTargetF (PredPCTargetF),
    .update      (updE),
    .pcE         (PCE),
    .takenE      (PCSrcResE),
    .targetE     (PCTargetE)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      predD   <= 1'b0;
      targetD <= '0;
    end else if (FlushD) begin
      predD   <= 1'b0;
      targetD <= '0;
    end else if (!StallD) begin
      predD   <= PCSrcPredF;
      targetD <= PredPCTargetF;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      predE   <= 1'b0;
      targetE <= '0;
    end else if (FlushE) begin
      predE   <= 1'b0;
      targetE <= '0;
    end else if (!StallE) begin
      predE   <= predD;
      targetE <= targetD;
    end
  end

  assign PCSrcPredE   = predE;
  assign TargetMatchE = (targetE == PCTargetE);

  // A stalled E will be presented again, so it neither trains nor counts now.
  assign updE        = BranchE & ~StallE;
  assign mispredictE = updE & ((predE != PCSrcResE) | (PCSrcResE & ~TargetMatchE));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      MispredictCount <= '0;
    end else if (mispredictE && (MispredictCount != 32'hFFFF_FFFF)) begin
      MispredictCount <= MispredictCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] PCF = '0, PCE = '0, PCTargetE = '0;
  logic        StallD = 0, FlushD = 0, StallE = 0, FlushE = 0, BranchE = 0, PCSrcResE = 0;
  logic        PCSrcPredF, PCSrcPredE, TargetMatchE;
  logic [31:0] PredPCTargetF, MispredictCount;

  always #5 clk = ~clk;

  branch_predictor #(.WIDTH(32), .ENTRIES(64)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .PCF             (PCF),
    .StallD          (StallD),
    .FlushD          (FlushD),
    .StallE          (StallE),
    .FlushE          (FlushE),
    .BranchE         (BranchE),
    .PCE             (PCE),
    .PCSrcResE       (PCSrcResE),
    .PCTargetE       (PCTargetE),
    .PCSrcPredF      (PCSrcPredF),
    .PredPCTargetF   (PredPCTargetF),
    .PCSrcPredE      (PCSrcPredE),
    .TargetMatchE    (TargetMatchE),
    .MispredictCount (MispredictCount)
  );

  // ---------------- scoreboard / checker ----------------
  int testsRun = 0;
  int testsFailed = 0;
  logic [31:0] exp_q[$];   // expected MispredictCount for the current cycle

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Table kept as plain arrays keyed by PC[7:2]; counter kept as an integer 0..3.
  bit          mValid [64];
  logic [23:0] mTag   [64];
  logic [31:0] mTarget[64];
  int          mCtr   [64];
  bit          mPredD, mPredE;
  logic [31:0] mTgtD, mTgtE;
  longint      mCount;

  function automatic void modelReset();
    for (int i = 0; i < 64; i++) begin
      mValid[i] = 0; mTag[i] = '0; mTarget[i] = '0; mCtr[i] = 1;
    end
    mPredD = 0; mPredE = 0; mTgtD = '0; mTgtE = '0; mCount = 0;
    exp_q.delete();
    exp_q.push_back(32'd0);
  endfunction

  function automatic void modelLookup(input logic [31:0] pc, output bit hit,
                                      output bit pred, output logic [31:0] tgt);
    int idx;
    idx  = int'(pc[7:2]);
    hit  = mValid[idx] && (mTag[idx] == pc[31:8]);
    pred = hit && (mCtr[idx] >= 2);
    tgt  = hit ? mTarget[idx] : 32'd0;
  endfunction

  // Advance the model across one rising edge using the inputs currently driven.
  function automatic void modelStep();
    bit fHit, fPred, eHit, wrong;
    logic [31:0] fTgt;
    int idx;
    modelLookup(PCF, fHit, fPred, fTgt);
    if (BranchE && !StallE) begin
      if (PCSrcResE) wrong = !mPredE || (mTgtE != PCTargetE);
      else           wrong = mPredE;
      if (wrong && mCount < 64'hFFFF_FFFF) mCount++;
      idx  = int'(PCE[7:2]);
      eHit = mValid[idx] && (mTag[idx] == PCE[31:8]);
      if (eHit) begin
        if (PCSrcResE) begin
          if (mCtr[idx] < 3) mCtr[idx]++;
          mTarget[idx] = PCTargetE;
        end else if (mCtr[idx] > 0) begin
          mCtr[idx]--;
        end
      end else if (PCSrcResE) begin
        mValid[idx] = 1; mTag[idx] = PCE[31:8]; mTarget[idx] = PCTargetE; mCtr[idx] = 2;
      end
    end
    if (FlushE)       begin mPredE = 0;      mTgtE = '0;    end
    else if (!StallE) begin mPredE = mPredD; mTgtE = mTgtD; end
    if (FlushD)       begin mPredD = 0;      mTgtD = '0;    end
    else if (!StallD) begin mPredD = fPred;  mTgtD = fTgt;  end
    void'(exp_q.pop_front());
    exp_q.push_back(32'(mCount));
  endfunction

  task automatic modelCheck();
    bit hit, pred;
    logic [31:0] tgt;
    modelLookup(PCF, hit, pred, tgt);
    checkEq("PCSrcPredF", {31'd0, PCSrcPredF}, {31'd0, pred});
    checkEq("PredPCTargetF", PredPCTargetF, tgt);
    checkEq("PCSrcPredE", {31'd0, PCSrcPredE}, {31'd0, mPredE});
    checkEq("TargetMatchE", {31'd0, TargetMatchE}, {31'd0, (mTgtE == PCTargetE)});
    checkEq("MispredictCount", MispredictCount, exp_q[0]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [31:0] pcf, input logic br, input logic [31:0] pce,
                       input logic res, input logic [31:0] tgt,
                       input logic sd, input logic fd, input logic se, input logic fe);
    PCF = pcf; BranchE = br; PCE = pce; PCSrcResE = res; PCTargetE = tgt;
    StallD = sd; FlushD = fd; StallE = se; FlushE = fe;
    #1;
    modelCheck();
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    modelReset();
    #1;
    modelCheck();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  function automatic logic [31:0] randPc();
    logic [31:0] p;
    p = {24'($urandom_range(0, 2)), 6'($urandom_range(0, 3)), 2'b00};
    return p;
  endfunction

  function automatic logic [31:0] randTarget();
    logic [31:0] t;
    case ($urandom_range(0, 3))
      0: t = 32'h40;
      1: t = 32'h80;
      2: t = 32'h90;
      default: t = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
    endcase
    return t;
  endfunction

  // ---------------- stimulus ----------------
  longint countBefore;

  initial begin
    @(negedge clk);
    doReset();

    // Reset state
    drive(32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
    checkEq("reset_predF", {31'd0, PCSrcPredF}, 32'd0);
    checkEq("reset_targetF", PredPCTargetF, 32'd0);
    checkEq("reset_count", MispredictCount, 32'd0);
    tick();

    // Allocate on a taken miss
    drive(32'h100, 1, 32'h100, 1, 32'h80, 0, 0, 0, 0);
    tick();
    drive(32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
    checkEq("alloc_predF", {31'd0, PCSrcPredF}, 32'd1);
    checkEq("alloc_targetF", PredPCTargetF, 32'h80);
    checkEq("alloc_count", MispredictCount, 32'd1);
    tick();

    // Hysteresis
    drive(32'h300, 1, 32'h100, 0, 32'h0, 0, 0, 0, 0);  tick();
    drive(32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
    checkEq("hyst_weak_nt", {31'd0, PCSrcPredF}, 32'd0);
    tick();
    drive(32'h300, 1, 32'h100, 1, 32'h80, 0, 0, 0, 0); tick();
    drive(32'h300, 1, 32'h100, 1, 32'h80, 0, 0, 0, 0); tick();
    drive(32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
    checkEq("hyst_strong_t", {31'd0, PCSrcPredF}, 32'd1);
    tick();
    drive(32'h300, 1, 32'h100, 0, 32'h0, 0, 0, 0, 0);  tick();
    drive(32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
    checkEq("hyst_weak_t", {31'd0, PCSrcPredF}, 32'd1);
    tick();

    // Alias replaces the entry at index 0
    drive(32'h300, 1, 32'h200, 1, 32'h40, 0, 0, 0, 0); tick();
    drive(32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
    checkEq("alias_old_pred", {31'd0, PCSrcPredF}, 32'd0);
    checkEq("alias_old_target", PredPCTargetF, 32'd0);
    drive(32'h200, 0, 0, 0, 0, 0, 0, 0, 0);
    checkEq("alias_new_pred", {31'd0, PCSrcPredF}, 32'd1);
    checkEq("alias_new_target", PredPCTargetF, 32'h40);
    tick();

    // Pipeline control
    drive(32'h300, 1, 32'h100, 1, 32'h80, 0, 0, 0, 0); tick();
    drive(32'h100, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(32'h300, 0, 0, 0, 0, 1, 0, 1, 0); tick();
    drive(32'h300, 0, 0, 0, 0, 1, 0, 1, 0); tick();
    drive(32'h300, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(32'h300, 0, 0, 0, 32'h80, 0, 0, 0, 0);
    checkEq("stallD_held_pred", {31'd0, PCSrcPredE}, 32'd1);
    checkEq("stallD_held_match", {31'd0, TargetMatchE}, 32'd1);
    drive(32'h300, 0, 0, 0, 32'h80, 0, 0, 1, 1); tick();
    drive(32'h300, 0, 0, 0, 32'h0, 0, 0, 0, 0);
    checkEq("flushE_pred", {31'd0, PCSrcPredE}, 32'd0);
    checkEq("flushE_match0", {31'd0, TargetMatchE}, 32'd1);
    drive(32'h300, 0, 0, 0, 32'h80, 0, 0, 0, 0);
    checkEq("flushE_match80", {31'd0, TargetMatchE}, 32'd0);
    drive(32'h300, 1, 32'h100, 0, 32'h0, 0, 0, 1, 0); tick();
    drive(32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
    checkEq("stallE_no_update", {31'd0, PCSrcPredF}, 32'd1);
    tick();

    // Target mispredict
    drive(32'h300, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(32'h300, 1, 32'h100, 1, 32'h90, 0, 0, 0, 0);
    checkEq("tgt_predE", {31'd0, PCSrcPredE}, 32'd1);
    checkEq("tgt_match", {31'd0, TargetMatchE}, 32'd0);
    countBefore = mCount;
    tick();
    drive(32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
    checkEq("tgt_count", MispredictCount, 32'(countBefore + 1));
    checkEq("tgt_retarget", PredPCTargetF, 32'h90);
    tick();

    // Reset mid-update: no write, count cleared
    drive(32'h300, 1, 32'h400, 1, 32'h44, 0, 0, 0, 0);
    doReset();
    drive(32'h400, 0, 0, 0, 0, 0, 0, 0, 0);
    checkEq("midreset_pred", {31'd0, PCSrcPredF}, 32'd0);
    checkEq("midreset_count", MispredictCount, 32'd0);
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) doReset();
      drive(randPc(), 1'($urandom_range(0, 1)), randPc(), 1'($urandom_range(0, 1)), randTarget(),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 11) == 0));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
